// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: initialises the register file, streams a program image
// into memory, then runs the CPU for a fixed or unbounded number of cycles.
module cpu_boot_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_DEPTH      = 256,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int RUN_CYCLES     = 5,
  parameter int INIT_MODE      = 0,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      load_valid,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      load_last,
  output logic                      load_ready,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      cpu_reset,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [MEM_ADDR_WIDTH:0]   words_loaded,
  output logic [CNT_WIDTH-1:0]      cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_LAST  = REG_ADDR_WIDTH'(REG_COUNT - 1);
  localparam logic [MEM_ADDR_WIDTH:0]   MEM_FULL  = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0]      RUN_LIMIT = CNT_WIDTH'(RUN_CYCLES);

  state_t                    state, state_n;
  logic [REG_ADDR_WIDTH-1:0] rf_idx, rf_idx_n;
  logic                      rf_we_n, mem_we_n, error_n;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_n;
  logic [DATA_WIDTH-1:0]     rf_wdata_n, mem_wdata_n;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_n;
  logic [MEM_ADDR_WIDTH:0]   words_n;
  logic [CNT_WIDTH-1:0]      cnt_n;
  logic                      accept;

  // load_ready is a registered image of "state is LOAD", so it qualifies acceptance
  assign accept = load_ready && load_valid;

  always_comb begin
    state_n     = state;
    rf_idx_n    = rf_idx;
    rf_we_n     = 1'b0;
    rf_waddr_n  = rf_waddr;
    rf_wdata_n  = rf_wdata;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    words_n     = words_loaded;
    cnt_n       = cycle_count;
    error_n     = error;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n  = S_INIT;
          rf_idx_n = '0;
          words_n  = '0;
          cnt_n    = '0;
          error_n  = 1'b0;
        end
      end
      S_INIT: begin
        rf_we_n    = 1'b1;
        rf_waddr_n = rf_idx;
        rf_wdata_n = (INIT_MODE == 0) ? DATA_WIDTH'(rf_idx) : '0;
        if (rf_idx == REG_LAST) state_n = S_LOAD;
        else                    rf_idx_n = rf_idx + 1'b1;
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = words_loaded[MEM_ADDR_WIDTH-1:0];
          mem_wdata_n = load_data;
          words_n     = words_loaded + 1'b1;
          if (load_last) begin
            state_n = S_RUN;
          end else if (words_n == MEM_FULL) begin
            // image did not end inside the memory: flag it and never start the CPU
            error_n = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      S_RUN: begin
        if ((RUN_CYCLES != 0) && (cycle_count == RUN_LIMIT)) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    // counts RUN cycles including the first; saturates for free-run
    if ((state_n == S_RUN) && (cycle_count != '1)) cnt_n = cycle_count + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_idx       <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cycle_count  <= '0;
      error        <= 1'b0;
      load_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cpu_reset    <= 1'b0;
    end else begin
      rf_idx       <= rf_idx_n;
      rf_we        <= rf_we_n;
      rf_waddr     <= rf_waddr_n;
      rf_wdata     <= rf_wdata_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      words_loaded <= words_n;
      cycle_count  <= cnt_n;
      error        <= error_n;
      load_ready   <= (state_n == S_LOAD);
      busy         <= (state_n == S_INIT) || (state_n == S_LOAD) || (state_n == S_RUN);
      done         <= (state_n == S_DONE);
      cpu_reset    <= (state_n == S_RUN);
    end
  end

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Synthesizable boot/run sequencer for the MIPS CPU in simulation and on FPGA. It initialises the register file, streams a program image into the unified memory over a valid/ready handshake, then releases the CPU's reset. It runs the CPU for a programmable number of cycles, or indefinitely, and holds the CPU in reset again when finished.

Parameters:
- DATA_WIDTH, 32: register-file and memory word width.
- REG_COUNT, 32: number of registers to initialise.
- REG_ADDR_WIDTH, 5: register index width; must satisfy 2^REG_ADDR_WIDTH >= REG_COUNT.
- MEM_DEPTH, 256: maximum number of program words accepted.
- MEM_ADDR_WIDTH, 8: word-address width; must satisfy 2^MEM_ADDR_WIDTH >= MEM_DEPTH.
- RUN_CYCLES, 5: number of cycles the CPU runs; 0 selects free-run (never leaves RUN).
- INIT_MODE, 0: register init pattern; 0 writes reg[i] = i, 1 writes all zeros.
- CNT_WIDTH, 32: width of cycle_count.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a boot sequence; honoured only in IDLE or DONE.
- load_valid, input, 1: program word valid.
- load_data, input, DATA_WIDTH: program word.
- load_last, input, 1: marks the final program word; qualified by load_valid.
- load_ready, output, 1: ready to accept a program word.
- rf_we, output, 1: register-file write enable.
- rf_waddr, output, REG_ADDR_WIDTH: register-file write index.
- rf_wdata, output, DATA_WIDTH: register-file write data.
- mem_we, output, 1: memory write enable.
- mem_addr, output, MEM_ADDR_WIDTH: memory word address.
- mem_wdata, output, DATA_WIDTH: memory write data.
- cpu_reset, output, 1: active-low reset driven to the CPU.
- busy, output, 1: high in INIT_REGS, LOAD_MEM and RUN.
- done, output, 1: high in DONE.
- error, output, 1: image overflow flag.
- words_loaded, output, MEM_ADDR_WIDTH+1: count of words accepted in the current boot.
- cycle_count, output, CNT_WIDTH: CPU cycles elapsed in RUN.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All write enables, load_ready, busy, done and error go to 0.
  - cpu_reset goes to 0; all counters and addresses go to 0.
  - Reset applies from any state, including mid-load and mid-run. Partially written state is abandoned and not resumed.
- Output timing: all outputs are registered. rf_* and mem_* appear the cycle after the decision that produces them.
- IDLE: start moves the FSM to INIT_REGS. This also clears error, words_loaded and cycle_count.
- INIT_REGS:
  - Issues exactly REG_COUNT writes on consecutive cycles, indices 0..REG_COUNT-1.
  - rf_wdata = zero-extended index when INIT_MODE=0, otherwise 0.
  - After the last write is issued, the FSM moves to LOAD_MEM. rf_we deasserts the following cycle.
- LOAD_MEM:
  - load_ready=1 throughout LOAD_MEM.
  - A word is accepted on a cycle where load_valid && load_ready.
  - Each accepted word produces mem_we=1 one cycle later, with mem_addr=words_loaded (pre-increment) and mem_wdata=the word. words_loaded increments.
  - A cycle without load_valid is a bubble: no write, no state change.
  - Accepted word with load_last=1: this is the final write; the FSM moves to RUN and load_ready drops the next cycle.
  - The MEM_DEPTH-th word accepted without load_last: written normally, then error=1 and the FSM moves to DONE. RUN is skipped and cpu_reset stays 0.
  - load_last on exactly the MEM_DEPTH-th word is legal: no error.
- RUN:
  - cpu_reset=1; cycle_count increments every cycle, starting at 1 in the first RUN cycle.
  - When RUN_CYCLES>0 and cycle_count reaches RUN_CYCLES, the FSM moves to DONE. cpu_reset returns to 0 in the same cycle done rises.
  - When RUN_CYCLES=0 the FSM stays in RUN until reset; cycle_count saturates at all-ones.
- DONE:
  - done=1; cycle_count, words_loaded and error hold their values.
  - start re-enters INIT_REGS, same as from IDLE.
- start while busy is ignored.
- rf_we and mem_we are never high in the same cycle.
- Stimulus on load_valid, load_data and load_last outside LOAD_MEM is ignored.

Test Plan:
- Identity init: INIT_MODE=0, pulse start → 32 consecutive rf writes with (addr,data) = (0,0)..(31,31), then load_ready=1.
- Zero init: INIT_MODE=1, pulse start → 32 rf writes, all with data 0.
- Gapped load: words 0x20080005, 0x20090003, 0x01095020 with idle cycles between them, last flagged → mem writes at addresses 0,1,2 with matching data; words_loaded=3; no write on gap cycles.
- Timed run: RUN_CYCLES=5 after the load → cpu_reset high for exactly 5 cycles; cycle_count=5; done=1; cpu_reset back to 0.
- Overflow: MEM_DEPTH=4, stream 4 words without last → 4 writes; error=1; done=1; cpu_reset never rises. A 5th word is not accepted.
- Mid-run reset: reset=0 on the 3rd RUN cycle → next cycle state is IDLE, cpu_reset=0, cycle_count=0. A new start repeats the full sequence.
